mips_mc_control: RTL and testbench



---
 rtl/mips_mc_control.sv | 187 ++++++++++++++++++
 tb/tb_mips_mc_control.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and drives every datapath mux, enable, memory strobe and the ALU select/c_in code.
module mips_mc_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [1:0] pc_src,
  output logic [4:0] alu_select,
  output logic       alu_cin,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] S_RESET  = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_IEXEC  = 4'd10;
  localparam logic [3:0] S_IWB    = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // {select, c_in} pairs understood by the ALU
  localparam logic [5:0] ALU_PASS_A = 6'b00000_0;
  localparam logic [5:0] ALU_ADD    = 6'b00001_0;
  localparam logic [5:0] ALU_SUB    = 6'b00010_1;
  localparam logic [5:0] ALU_AND    = 6'b00100_0;
  localparam logic [5:0] ALU_OR     = 6'b00101_0;
  localparam logic [5:0] ALU_XOR    = 6'b00110_0;
  localparam logic [5:0] ALU_NOR    = 6'b00101_1;

  logic [3:0] state_q, state_d;
  logic [5:0] alu_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  assign state = state_q;
  assign {alu_select, alu_cin} = alu_code;

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    imm_zext   = 1'b0;
    pc_src     = 2'b00;
    illegal_op = 1'b0;
    alu_code   = ALU_PASS_A;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_code  = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_code  = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW:             state_d = S_MEMADR;
          OP_RTYPE:                 state_d = (funct[5:3] == 3'b100) ? S_EXEC : S_TRAP;
          OP_BEQ, OP_BNE:           state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
          OP_J:                     state_d = S_JUMP;
          default:                  state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_code  = ALU_ADD;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        state_d   = S_ALUWB;
        case (funct)
          6'h20, 6'h21: alu_code = ALU_ADD;
          6'h22, 6'h23: alu_code = ALU_SUB;
          6'h24:        alu_code = ALU_AND;
          6'h25:        alu_code = ALU_OR;
          6'h26:        alu_code = ALU_XOR;
          6'h27:        alu_code = ALU_NOR;
          default:      alu_code = ALU_PASS_A;
        endcase
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        // opcode bit 0 separates bne from beq
        alu_src_a = 1'b1;
        alu_code  = ALU_SUB;
        pc_src    = 2'b01;
        pc_en     = opcode[0] ? ~zero : zero;
        state_d   = S_FETCH;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_IWB;
        case (opcode)
          OP_ANDI: begin alu_code = ALU_AND; imm_zext = 1'b1; end
          OP_ORI:  begin alu_code = ALU_OR;  imm_zext = 1'b1; end
          default: alu_code = ALU_ADD;
        endcase
      end
      S_IWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        illegal_op = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized scoreboard bench for mips_mc_control: the driver expands each
// instruction into its expected per-cycle control words; a monitor checks them.
module tb_mips_mc_control;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [1:0] pc_src;
    logic [4:0] alu_select;
    logic       alu_cin, illegal_op;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, imm_zext, alu_cin, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [4:0] alu_select;
  logic [3:0] state;

  mips_mc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_zext(imm_zext), .pc_src(pc_src),
    .alu_select(alu_select), .alu_cin(alu_cin), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  ctl_t act;
  assign act = {state, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, imm_zext, pc_src,
                alu_select, alu_cin, illegal_op};

  localparam logic [5:0] ADD = 6'b00001_0, SUB = 6'b00010_1, AND_ = 6'b00100_0;
  localparam logic [5:0] OR_ = 6'b00101_0, XOR_ = 6'b00110_0, NOR_ = 6'b00101_1;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101, JMP = 6'b000010;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  ctl_t exp_q[$];
  logic [5:0] cur_op = 6'd0, cur_fn = 6'd0;

  function automatic ctl_t blank(input logic [3:0] s);
    ctl_t c = '0;
    c.state = s;
    return c;
  endfunction

  function automatic ctl_t with_alu(input ctl_t c, input logic [5:0] code);
    {c.alu_select, c.alu_cin} = code;
    return c;
  endfunction

  function automatic logic [5:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20, 6'h21: return ADD;
      6'h22, 6'h23: return SUB;
      6'h24:        return AND_;
      6'h25:        return OR_;
      6'h26:        return XOR_;
      default:      return NOR_;
    endcase
  endfunction

  task automatic check(input string name, input ctl_t got, input ctl_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctl_t e;
      e = exp_q.pop_front();
      cyc++;
      check($sformatf("cycle%0d", cyc), act, e);
    end
  end

  task automatic step(input ctl_t e, input logic mr, input logic z);
    @(posedge clk);
    #1;
    opcode = cur_op; funct = cur_fn; mem_ready = mr; zero = z;
    exp_q.push_back(e);
  endtask

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  task automatic do_reset(input int hold);
    ctl_t z = '0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("rst_async", act, z);
    for (int i = 0; i < hold; i++) step(z, rnd(), rnd());
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back(z);
  endtask

  task automatic fetch_decode(input int wf);
    ctl_t e;
    e = with_alu(blank(4'd1), ADD);
    e.mem_read = 1'b1; e.alu_src_b = 2'b01;
    for (int w = 0; w < wf; w++) step(e, 1'b0, rnd());
    e.ir_write = 1'b1; e.pc_en = 1'b1;
    step(e, 1'b1, rnd());
    e = with_alu(blank(4'd2), ADD);
    e.alu_src_b = 2'b11;
    step(e, rnd(), rnd());
  endtask

  task automatic memadr();
    ctl_t e;
    e = with_alu(blank(4'd3), ADD);
    e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
    step(e, rnd(), rnd());
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int wf, input int wm);
    ctl_t e;
    cur_op = op; cur_fn = fn;
    fetch_decode(wf);
    if (op == LW) begin
      memadr();
      e = blank(4'd4); e.i_or_d = 1'b1; e.mem_read = 1'b1;
      for (int w = 0; w < wm; w++) step(e, 1'b0, rnd());
      step(e, 1'b1, rnd());
      e = blank(4'd5); e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
      step(e, rnd(), rnd());
    end else if (op == SW) begin
      memadr();
      e = blank(4'd6); e.i_or_d = 1'b1; e.mem_write = 1'b1;
      for (int w = 0; w < wm; w++) step(e, 1'b0, rnd());
      step(e, 1'b1, rnd());
    end else if (op == 6'd0 && fn >= 6'h20 && fn <= 6'h27) begin
      e = with_alu(blank(4'd7), r_alu(fn)); e.alu_src_a = 1'b1;
      step(e, rnd(), rnd());
      e = blank(4'd8); e.reg_dst = 1'b1; e.reg_write = 1'b1;
      step(e, rnd(), rnd());
    end else if (op == BEQ || op == BNE) begin
      e = with_alu(blank(4'd9), SUB); e.alu_src_a = 1'b1; e.pc_src = 2'b01;
      e.pc_en = (op == BEQ) ? z : ~z;
      step(e, rnd(), z);
    end else if (op == ADDI || op == ANDI || op == ORI) begin
      e = with_alu(blank(4'd10), (op == ADDI) ? ADD : (op == ANDI) ? AND_ : OR_);
      e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.imm_zext = (op != ADDI);
      step(e, rnd(), rnd());
      e = blank(4'd11); e.reg_write = 1'b1;
      step(e, rnd(), rnd());
    end else if (op == JMP) begin
      e = blank(4'd12); e.pc_src = 2'b10; e.pc_en = 1'b1;
      step(e, rnd(), rnd());
    end else begin
      e = blank(4'd13); e.illegal_op = 1'b1;
      step(e, rnd(), rnd());
    end
  endtask

  task automatic rand_instr();
    logic [5:0] ops [9];
    logic [5:0] op, fn;
    ops = '{LW, SW, 6'd0, BEQ, BNE, ADDI, ANDI, ORI, JMP};
    op = (($urandom_range(0, 7)) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
    fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : {3'b100, 3'($urandom)};
    run_instr(op, fn, rnd(), $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0,
              $urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    ctl_t e;
    do_reset(2);
    run_instr(6'd0, 6'h27, 1'b0, 0, 0);   // nor
    run_instr(LW, 6'h00, 1'b0, 0, 2);     // lw with two wait cycles
    run_instr(BEQ, 6'h00, 1'b1, 0, 0);
    run_instr(BNE, 6'h00, 1'b1, 0, 0);
    run_instr(6'h3F, 6'h00, 1'b0, 1, 0);  // illegal opcode
    run_instr(6'd0, 6'h00, 1'b0, 0, 0);   // illegal funct
    for (int i = 0; i < 120; i++) rand_instr();
    // Reset while a store is stalled in MEMWR
    cur_op = SW; cur_fn = 6'h00;
    fetch_decode(0);
    memadr();
    e = blank(4'd6); e.i_or_d = 1'b1; e.mem_write = 1'b1;
    step(e, 1'b0, 1'b0);
    do_reset(3);
    run_instr(ORI, 6'h00, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
